// File: rtl/xlnx_clk_div_chan.sv
// One divider channel: period counter, active/pending divisor pair and
// registered clock/tick outputs. Divisor changes and enable changes only
// take effect at a period boundary, so the divided clock never glitches.
module xlnx_clk_div_chan #(
    parameter int CntWidth   = 16,
    parameter int DefaultDiv = 50
) (
    input  logic                soc_clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic                align_i,
    input  logic [CntWidth-1:0] div_i,
    input  logic                div_valid_i,
    output logic                div_ready_o,
    output logic                clk_o,
    output logic                tick_o,
    output logic                active_o
);

    // Divisors below MinDiv cannot produce both a high and a low phase.
    localparam logic [CntWidth-1:0] MinDiv   = CntWidth'(2);
    localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1);
    localparam logic [CntWidth-1:0] ResetDiv = CntWidth'(DefaultDiv);
    localparam logic [CntWidth-1:0] ResetCnt = CntWidth'(DefaultDiv - 1);

    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [CntWidth-1:0] div_q, div_d;
    logic [CntWidth-1:0] pend_div_q, pend_div_d;
    logic                pend_q, pend_d;
    logic                run_q, run_d;
    logic                clk_q, clk_d;
    logic                tick_q, tick_d;

    logic [CntWidth-1:0] eff_div;
    logic [CntWidth-1:0] eff_div_next;
    logic [CntWidth-1:0] hi_next;
    logic                wrap;
    logic                accept;

    function automatic logic [CntWidth-1:0] clamp_div(input logic [CntWidth-1:0] d);
        return (d < MinDiv) ? MinDiv : d;
    endfunction

    // Next-state logic: a boundary is either the natural end of the period or
    // an align request on an enabled channel; both collapse into one wrap.
    always_comb begin
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_div_d = pend_div_q;
        run_d      = run_q;

        eff_div = clamp_div(div_q);
        accept  = div_valid_i & ~pend_q;
        wrap    = (cnt_q == (eff_div - CntOne)) | (align_i & en_i);

        if (wrap) begin
            run_d = en_i;
            if (pend_q) begin
                div_d  = pend_div_q;
                pend_d = 1'b0;
            end
        end

        eff_div_next = clamp_div(div_d);
        hi_next      = eff_div_next - (eff_div_next >> 1);

        if (wrap) begin
            cnt_d = run_d ? '0 : (eff_div_next - CntOne);
        end else if (run_q) begin
            cnt_d = cnt_q + CntOne;
        end

        if (accept) begin
            pend_d     = 1'b1;
            pend_div_d = div_i;
        end

        clk_d  = run_d & (cnt_d < hi_next);
        tick_d = run_d & wrap & (cnt_d == '0);
    end

    // State and output registers; reset parks the channel at the end of a
    // default-length period so the first enable starts a fresh period.
    always_ff @(posedge soc_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= ResetCnt;
            div_q      <= ResetDiv;
            pend_div_q <= '0;
            pend_q     <= 1'b0;
            run_q      <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_div_q <= pend_div_d;
            pend_q     <= pend_d;
            run_q      <= run_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
        end
    end

    assign div_ready_o = ~pend_q;
    assign clk_o       = clk_q;
    assign tick_o      = tick_q;
    assign active_o    = run_q;

endmodule

// File: rtl/xlnx_clk_div_bank.sv
// Bank of independent programmable clock/tick dividers. Channel 0 feeds the
// SoC RTC input; the remaining channels provide PWM timebases and strobes.
// The align pulse is shared so every enabled channel restarts in phase.
module xlnx_clk_div_bank #(
    parameter int NumChannels = 2,
    parameter int CntWidth    = 16,
    parameter int DefaultDiv  = 50
) (
    input  logic                                soc_clk,
    input  logic                                rst_n,
    input  logic [NumChannels-1:0]              en_i,
    input  logic [NumChannels-1:0][CntWidth-1:0] div_i,
    input  logic [NumChannels-1:0]              div_valid_i,
    output logic [NumChannels-1:0]              div_ready_o,
    input  logic                                align_i,
    output logic [NumChannels-1:0]              clk_o,
    output logic [NumChannels-1:0]              tick_o,
    output logic [NumChannels-1:0]              active_o
);

    // One divider per channel, all sharing clock, reset and align.
    for (genvar ch = 0; ch < NumChannels; ch++) begin : g_chan
        xlnx_clk_div_chan #(
            .CntWidth   (CntWidth),
            .DefaultDiv (DefaultDiv)
        ) u_chan (
            .soc_clk     (soc_clk),
            .rst_n       (rst_n),
            .en_i        (en_i[ch]),
            .align_i     (align_i),
            .div_i       (div_i[ch]),
            .div_valid_i (div_valid_i[ch]),
            .div_ready_o (div_ready_o[ch]),
            .clk_o       (clk_o[ch]),
            .tick_o      (tick_o[ch]),
            .active_o    (active_o[ch])
        );
    end

endmodule

// File: tb/tb_xlnx_clk_div_bank.sv
// Testbench for xlnx_clk_div_bank: directed scenarios with hand-computed
// periods plus a long randomized run, all shadowed by a period-level model.
module tb_xlnx_clk_div_bank;

    localparam int NumChannels = 2;
    localparam int CntWidth    = 16;
    localparam int DefaultDiv  = 50;

    logic                                 soc_clk = 1'b0;
    logic                                 rst_n;
    logic [NumChannels-1:0]               en_i;
    logic [NumChannels-1:0][CntWidth-1:0] div_i;
    logic [NumChannels-1:0]               div_valid_i;
    logic [NumChannels-1:0]               div_ready_o;
    logic                                 align_i;
    logic [NumChannels-1:0]               clk_o;
    logic [NumChannels-1:0]               tick_o;
    logic [NumChannels-1:0]               active_o;

    int testsRun    = 0;
    int testsFailed = 0;
    bit started     = 1'b0;

    // Model of one channel in terms of "position within the current period".
    typedef struct packed {
        logic run;
        int   pos;
        int   div;
        logic pend;
        int   pendDiv;
        logic clk;
        logic tick;
    } chanModelT;

    chanModelT model [NumChannels];

    xlnx_clk_div_bank #(
        .NumChannels (NumChannels),
        .CntWidth    (CntWidth),
        .DefaultDiv  (DefaultDiv)
    ) dut (
        .soc_clk     (soc_clk),
        .rst_n       (rst_n),
        .en_i        (en_i),
        .div_i       (div_i),
        .div_valid_i (div_valid_i),
        .div_ready_o (div_ready_o),
        .align_i     (align_i),
        .clk_o       (clk_o),
        .tick_o      (tick_o),
        .active_o    (active_o)
    );

    // System clock, 10 time units per cycle.
    always #5 soc_clk = ~soc_clk;

    function automatic chanModelT resetChan();
        chanModelT s;
        s.run     = 1'b0;
        s.pos     = DefaultDiv - 1;
        s.div     = DefaultDiv;
        s.pend    = 1'b0;
        s.pendDiv = 0;
        s.clk     = 1'b0;
        s.tick    = 1'b0;
        return s;
    endfunction

    // One soc_clk step: a period of length d is high for the first
    // ceil(d/2) positions; divisors below 2 count as 2.
    function automatic chanModelT stepChan(chanModelT s, logic en, logic valid,
                                           int divIn, logic align);
        chanModelT n;
        int  d;
        int  nd;
        bit  accept;
        bit  atEnd;
        n      = s;
        d      = (s.div < 2) ? 2 : s.div;
        accept = valid && !s.pend;
        atEnd  = (s.pos == d - 1) || (align && en);
        n.tick = 1'b0;
        if (atEnd) begin
            if (s.pend) begin
                n.div  = s.pendDiv;
                n.pend = 1'b0;
            end
            nd     = (n.div < 2) ? 2 : n.div;
            n.run  = en;
            n.pos  = en ? 0 : nd - 1;
            n.clk  = en;
            n.tick = en;
        end else if (s.run) begin
            n.pos = s.pos + 1;
            n.clk = (n.pos < (d + 1) / 2);
        end else begin
            n.clk = 1'b0;
        end
        if (accept) begin
            n.pend    = 1'b1;
            n.pendDiv = divIn;
        end
        return n;
    endfunction

    // Advance the model on each clock edge; reset it asynchronously.
    always @(posedge soc_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NumChannels; c++) model[c] <= resetChan();
        end else begin
            for (int c = 0; c < NumChannels; c++)
                model[c] <= stepChan(model[c], en_i[c], div_valid_i[c],
                                     int'(div_i[c]), align_i);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Compare every channel against the model on each falling edge.
    always @(negedge soc_clk) begin
        if (started) begin
            for (int c = 0; c < NumChannels; c++) begin
                checkOutput($sformatf("chan%0d {clk,tick,active,ready}", c),
                            {28'd0, clk_o[c], tick_o[c], active_o[c], div_ready_o[c]},
                            {28'd0, model[c].clk, model[c].tick, model[c].run, ~model[c].pend});
            end
        end
    end

    task automatic nextCycle(input int n = 1);
        repeat (n) begin
            @(posedge soc_clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [NumChannels-1:0] en,
                                 input logic [NumChannels-1:0] valid,
                                 input logic [NumChannels-1:0][CntWidth-1:0] divs,
                                 input logic align);
        en_i        = en;
        div_valid_i = valid;
        div_i       = divs;
        align_i     = align;
    endtask

    // Hold a divisor write until the handshake completes.
    task automatic writeDiv(input int ch, input int val);
        bit acc;
        bit done;
        done            = 1'b0;
        div_i[ch]       = CntWidth'(val);
        div_valid_i[ch] = 1'b1;
        for (int k = 0; k < 300 && !done; k++) begin
            acc = div_ready_o[ch];
            nextCycle();
            if (acc) done = 1'b1;
        end
        div_valid_i[ch] = 1'b0;
        if (!done) checkOutput("writeDiv handshake timeout", 0, 1);
    endtask

    task automatic waitTick(input int ch, output int waited);
        waited = 0;
        do begin
            nextCycle();
            waited++;
        end while (!tick_o[ch] && waited < 300);
        if (!tick_o[ch]) checkOutput("waitTick timeout", 0, 1);
    endtask

    // Starting on a tick cycle, count high and low cycles of one period.
    task automatic measurePeriod(input int ch, input int expHi, input int expLo);
        int hi;
        int lo;
        hi = 0;
        lo = 0;
        while (clk_o[ch] && hi < 300) begin
            hi++;
            nextCycle();
        end
        while (!clk_o[ch] && !tick_o[ch] && lo < 300) begin
            lo++;
            nextCycle();
        end
        checkOutput($sformatf("chan%0d high cycles", ch), hi, expHi);
        checkOutput($sformatf("chan%0d low cycles", ch), lo, expLo);
        checkOutput($sformatf("chan%0d tick at period start", ch), tick_o[ch], 1);
    endtask

    // Safety net in case the stimulus stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        int hi;
        int lo;
        int idleHits;
        logic [11:0] ticks0;
        logic [11:0] ticks1;
        logic [NumChannels-1:0] rEn;
        logic [NumChannels-1:0] rValid;
        logic [NumChannels-1:0][CntWidth-1:0] rDiv;
        logic rAlign;

        rst_n = 1'b0;
        applyStimulus('0, '0, '0, 1'b0);
        nextCycle(3);
        checkOutput("reset clk_o", clk_o, 0);
        checkOutput("reset tick_o", tick_o, 0);
        checkOutput("reset active_o", active_o, 0);
        checkOutput("reset div_ready_o", div_ready_o, 3);
        started = 1'b1;
        rst_n   = 1'b1;
        nextCycle(2);

        // Default divisor 50: first tick one cycle after enable.
        en_i[0] = 1'b1;
        nextCycle();
        checkOutput("start clk_o[0]", clk_o[0], 1);
        checkOutput("start tick_o[0]", tick_o[0], 1);
        checkOutput("start active_o[0]", active_o[0], 1);
        measurePeriod(0, 25, 25);
        measurePeriod(0, 25, 25);

        // Reprogram to 5 while running; applies at the next wrap.
        writeDiv(0, 5);
        checkOutput("ready low while pending", div_ready_o[0], 0);
        waitTick(0, waited);
        checkOutput("old period completes", waited, 49);
        checkOutput("ready back after apply", div_ready_o[0], 1);
        measurePeriod(0, 3, 2);
        measurePeriod(0, 3, 2);

        // Back-to-back writes: 9 waits until 7 has applied.
        writeDiv(0, 7);
        writeDiv(0, 9);
        waitTick(0, waited);
        checkOutput("divisor 7 period remainder", waited, 6);
        measurePeriod(0, 5, 4);

        // Disable at the start of a D=10 period: full period then park.
        writeDiv(0, 10);
        waitTick(0, waited);
        checkOutput("divisor 9 period remainder", waited, 8);
        en_i[0] = 1'b0;
        hi = 0;
        lo = 0;
        while (clk_o[0] && hi < 50) begin
            hi++;
            nextCycle();
        end
        while (!clk_o[0] && active_o[0] && lo < 50) begin
            lo++;
            nextCycle();
        end
        checkOutput("disable high cycles", hi, 5);
        checkOutput("disable low cycles", lo, 5);
        checkOutput("disabled active_o[0]", active_o[0], 0);
        idleHits = 0;
        for (int k = 0; k < 20; k++) begin
            if (clk_o[0] || tick_o[0]) idleHits++;
            nextCycle();
        end
        checkOutput("parked channel activity", idleHits, 0);

        // Two misaligned channels brought into phase by align.
        writeDiv(0, 4);
        writeDiv(1, 6);
        en_i[1] = 1'b1;
        nextCycle(3);
        en_i[0] = 1'b1;
        nextCycle(5);
        align_i = 1'b1;
        nextCycle();
        align_i = 1'b0;
        checkOutput("align clk_o", clk_o, 3);
        checkOutput("align tick_o", tick_o, 3);
        for (int k = 0; k < 12; k++) begin
            nextCycle();
            ticks0[k] = tick_o[0];
            ticks1[k] = tick_o[1];
        end
        checkOutput("post-align ticks chan0", ticks0, 12'h888);
        checkOutput("post-align ticks chan1", ticks1, 12'h820);

        // Divisors 0 and 1 behave as 2.
        writeDiv(0, 0);
        waitTick(0, waited);
        measurePeriod(0, 1, 1);
        writeDiv(0, 1);
        waitTick(0, waited);
        checkOutput("divisor 0 acts as 2", waited, 1);
        measurePeriod(0, 1, 1);

        // Randomized traffic, checked cycle by cycle against the model.
        rEn = en_i;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < NumChannels; c++) begin
                if ($urandom_range(0, 99) < 3) rEn[c] = ~rEn[c];
                rValid[c] = ($urandom_range(0, 99) < 20);
                rDiv[c]   = CntWidth'($urandom_range(0, 12));
            end
            rAlign = ($urandom_range(0, 99) < 2);
            applyStimulus(rEn, rValid, rDiv, rAlign);
            nextCycle();
        end
        applyStimulus('1, '0, '0, 1'b0);

        // Asynchronous reset mid-period returns everything to defaults.
        nextCycle(7);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset clk_o", clk_o, 0);
        checkOutput("async reset tick_o", tick_o, 0);
        checkOutput("async reset active_o", active_o, 0);
        checkOutput("async reset div_ready_o", div_ready_o, 3);
        nextCycle(2);
        rst_n = 1'b1;
        nextCycle();
        checkOutput("restart tick_o[0]", tick_o[0], 1);
        measurePeriod(0, 25, 25);

        nextCycle(2);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
